// File: rtl/dm_ext_unit_pkg.sv
// Shared pipeline package: load-extension opcodes, the combined result type,
// and the sign/zero extension helpers used by the load path.
package dm_ext_unit_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LH  = 3'b100;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } ld_res_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic [31:0] r;
    r = {{24{sgn & b[7]}}, b};
    return r;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic [31:0] r;
    r = {{16{sgn & h[15]}}, h};
    return r;
  endfunction

endpackage

// File: rtl/dm_ext_unit_load_ext_comb.sv
// Combinational byte/halfword select and extend for data-memory loads,
// plus the misalignment / illegal-opcode flag.
module load_ext_comb
  import dm_ext_unit_pkg::*;
(
  input  logic [1:0]  a_i,
  input  logic [31:0] din_i,
  input  logic [2:0]  op_i,
  output ld_res_t     res_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Little-endian byte lane select
  always_comb begin
    byte_s = 8'h00;
    case (a_i)
      2'b00:   byte_s = din_i[7:0];
      2'b01:   byte_s = din_i[15:8];
      2'b10:   byte_s = din_i[23:16];
      2'b11:   byte_s = din_i[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Halfword lane select: A[0] only affects the error flag, never the data
  always_comb begin
    half_s = 16'h0000;
    if (a_i[1]) begin
      half_s = din_i[31:16];
    end else begin
      half_s = din_i[15:0];
    end
  end

  // Extension and error flag per opcode; illegal opcodes pass the raw word
  always_comb begin
    res_o.data = din_i;
    res_o.err  = 1'b0;
    case (op_i)
      OP_LW: begin
        res_o.data = din_i;
        res_o.err  = (a_i != 2'b00);
      end
      OP_LBU: begin
        res_o.data = ext_byte(byte_s, 1'b0);
        res_o.err  = 1'b0;
      end
      OP_LB: begin
        res_o.data = ext_byte(byte_s, 1'b1);
        res_o.err  = 1'b0;
      end
      OP_LHU: begin
        res_o.data = ext_half(half_s, 1'b0);
        res_o.err  = a_i[0];
      end
      OP_LH: begin
        res_o.data = ext_half(half_s, 1'b1);
        res_o.err  = a_i[0];
      end
      default: begin
        res_o.data = din_i;
        res_o.err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dm_ext_unit.sv
// Data-memory load extension unit: one-cycle registered select/extend of the
// raw memory word, with a registered misalignment / illegal-op flag.
module dm_ext_unit
  import dm_ext_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  A,
  input  logic [31:0] Din,
  input  logic [2:0]  Op,
  output logic [31:0] Dout,
  output logic        Err
);

  ld_res_t     res_d;
  logic [31:0] dout_q;
  logic        err_q;

  load_ext_comb u_load_ext_comb (
    .a_i   (A),
    .din_i (Din),
    .op_i  (Op),
    .res_o (res_d)
  );

  // Output register; reset drops whatever result was in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= RESET_VAL;
      err_q  <= 1'b0;
    end else begin
      dout_q <= res_d.data;
      err_q  <= res_d.err;
    end
  end

  assign Dout = dout_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_dm_ext_unit.sv
// Scoreboard bench for dm_ext_unit: directed vectors push expected results,
// an independent monitor pops and compares one result per clock edge.
module tb_dm_ext_unit;
  import dm_ext_unit_pkg::*;

  localparam logic [31:0] RV = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  A = 2'b00;
  logic [31:0] Din = 32'h0000_0000;
  logic [2:0]  Op = 3'b000;
  logic [31:0] Dout;
  logic        Err;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  dm_ext_unit #(.RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .Din   (Din),
    .Op    (Op),
    .Dout  (Dout),
    .Err   (Err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [1:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic [31:0] ed, input logic ee,
                       input string nm);
    exp_t e;
    @(negedge clk);
    reset = r;
    A     = a;
    Din   = d;
    Op    = op;
    e.name = nm;
    e.data = ed;
    e.err  = ee;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge produces exactly one result for the vector driven before it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (Dout === e.data && Err === e.err) begin
          passed++;
        end else begin
          $display("FAIL %s: got Dout=%h Err=%b, expected Dout=%h Err=%b",
                   e.name, Dout, Err, e.data, e.err);
        end
      end
    end
  end

  initial begin
    drive(1'b1, 2'b00, 32'h1234_5678, OP_LW,  RV,           1'b0, "reset0");
    drive(1'b1, 2'b11, 32'hFFFF_FFFF, 3'b111, RV,           1'b0, "reset1");
    drive(1'b0, 2'b01, 32'h0000_FFFF, OP_LB,  32'hFFFF_FFFF, 1'b0, "lb_a1_ff");
    drive(1'b0, 2'b01, 32'h0000_FFFF, OP_LBU, 32'h0000_00FF, 1'b0, "lbu_a1_ff");
    drive(1'b0, 2'b10, 32'h0000_FFFF, OP_LB,  32'h0000_0000, 1'b0, "lb_a2_00");
    drive(1'b0, 2'b10, 32'h8001_7FFF, OP_LH,  32'hFFFF_8001, 1'b0, "lh_a2_neg");
    drive(1'b0, 2'b10, 32'h8001_7FFF, OP_LHU, 32'h0000_8001, 1'b0, "lhu_a2");
    drive(1'b0, 2'b11, 32'h8001_7FFF, OP_LHU, 32'h0000_8001, 1'b1, "lhu_a3_mis");
    drive(1'b0, 2'b00, 32'hDEAD_BEEF, OP_LW,  32'hDEAD_BEEF, 1'b0, "lw_a0");
    drive(1'b0, 2'b01, 32'hDEAD_BEEF, OP_LW,  32'hDEAD_BEEF, 1'b1, "lw_a1_mis");
    drive(1'b0, 2'b10, 32'hDEAD_BEEF, OP_LW,  32'hDEAD_BEEF, 1'b1, "lw_a2_mis");
    drive(1'b0, 2'b00, 32'hDEAD_BEEF, 3'b111, 32'hDEAD_BEEF, 1'b1, "ill_111");
    drive(1'b0, 2'b00, 32'h1357_9BDF, 3'b101, 32'h1357_9BDF, 1'b1, "ill_101");
    drive(1'b0, 2'b10, 32'h1357_9BDF, 3'b110, 32'h1357_9BDF, 1'b1, "ill_110");
    drive(1'b0, 2'b00, 32'h80C3_7F12, OP_LB,  32'h0000_0012, 1'b0, "lb_a0");
    drive(1'b0, 2'b01, 32'h80C3_7F12, OP_LB,  32'h0000_007F, 1'b0, "lb_a1");
    drive(1'b0, 2'b10, 32'h80C3_7F12, OP_LB,  32'hFFFF_FFC3, 1'b0, "lb_a2");
    drive(1'b0, 2'b11, 32'h80C3_7F12, OP_LB,  32'hFFFF_FF80, 1'b0, "lb_a3");
    drive(1'b0, 2'b11, 32'h80C3_7F12, OP_LBU, 32'h0000_0080, 1'b0, "lbu_a3");
    drive(1'b0, 2'b00, 32'h1234_8765, OP_LH,  32'hFFFF_8765, 1'b0, "lh_a0");
    drive(1'b0, 2'b01, 32'h1234_8765, OP_LHU, 32'h0000_8765, 1'b1, "lhu_a1_mis");
    drive(1'b0, 2'b11, 32'h1234_8765, OP_LH,  32'h0000_1234, 1'b1, "lh_a3_mis");
    drive(1'b1, 2'b00, 32'h0000_00FF, OP_LB,  RV,           1'b0, "reset_mid");
    drive(1'b0, 2'b00, 32'h0000_00FF, OP_LB,  32'hFFFF_FFFF, 1'b0, "after_reset");
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dm_ext_unit.md
DM_EXT_UNIT -- requirements
Module: dm_ext_unit

Interface
Parameters (name, default, meaning):
REQ-001 The module SHALL have parameter RESET_VAL, default 32'h0000_0000, the value loaded into Dout on reset.

Ports (name, direction, width, meaning):
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port A, input, 2, the byte offset within the word (low address bits).
REQ-005 The module SHALL have port Din, input, 32, the raw word read from data memory.
REQ-006 The module SHALL have port Op, input, 3, the load-extension operation code.
REQ-007 The module SHALL have port Dout, output, 32, the registered extended load result.
REQ-008 The module SHALL have port Err, output, 1, the registered misalignment or illegal-Op flag.

Function
REQ-009 Op encoding SHALL be: 000 word (LW), 001 byte zero-extend (LBU), 010 byte sign-extend (LB), 011 half zero-extend (LHU), 100 half sign-extend (LH); 101-111 are illegal.
REQ-010 Byte select SHALL be: A=00 -> Din[7:0], 01 -> Din[15:8], 10 -> Din[23:16], 11 -> Din[31:24] (little-endian).
REQ-011 Halfword select SHALL use A[1] only: 0 -> Din[15:0], 1 -> Din[31:16]; A[0] is ignored for data selection.
REQ-012 Sign extension SHALL replicate bit 7 (byte) or bit 15 (half) of the selected field into all upper bits; zero extension SHALL fill the upper bits with 0.
REQ-013 Op=000 SHALL pass Din unchanged regardless of A.
REQ-014 Illegal Op SHALL pass Din unchanged to Dout and set Err=1.
REQ-015 Err SHALL be 1 when Op is 011/100 and A[0]=1, when Op=000 and A!=00, or when Op is illegal; Err SHALL be 0 otherwise (byte ops are never misaligned).
REQ-016 Latency SHALL be exactly one cycle: Dout/Err at edge N+1 reflect A/Din/Op sampled at edge N, every cycle, with no handshake and no stall.
REQ-017 Dout SHALL carry the extended data even when Err=1; consumers decide whether to trap.

Reset
REQ-018 When reset=1 at a rising edge, Dout SHALL become RESET_VAL and Err SHALL become 0, overriding any input.
REQ-019 The first edge with reset=0 SHALL register the current inputs normally; reset asserted mid-stream SHALL discard the in-flight result.

Structure
REQ-020 The Op encodings (OP_LW, OP_LBU, OP_LB, OP_LHU, OP_LH) SHALL be localparam constants in the shared pipeline package, also used by the decoder.
REQ-021 The combinational select-and-extend logic SHALL be one sub-module, load_ext_comb, with the output register in dm_ext_unit.

Verification
REQ-022 A=01, Din=32'h0000FFFF, Op=010 -> after one edge, Dout=32'hFFFFFFFF, Err=0.
REQ-023 A=01, Din=32'h0000FFFF, Op=001 -> Dout=32'h000000FF; A=10, same Din, Op=010 -> Dout=32'h00000000.
REQ-024 A=10, Din=32'h8001_7FFF, Op=100 -> Dout=32'hFFFF8001; Op=011 -> Dout=32'h00008001; A=11, Op=011 -> Err=1.
REQ-025 A=00, Din=32'hDEADBEEF, Op=000 -> Dout=32'hDEADBEEF, Err=0; same with A=01 -> Err=1; Op=111 -> Dout=32'hDEADBEEF, Err=1.
REQ-026 Reset asserted while Op=010, Din=32'h000000FF -> Dout=RESET_VAL, Err=0 that cycle; after release, Dout=32'hFFFFFFFF after one edge.
